fetch_sequencer: RTL

Instruction-fetch controller for the RV32 core. It owns the program-counter value, chooses the next fetch address from three sources (trap vector, branch/jump redirect, or PC+4), and drives a single-outstanding valid/ready request to instruction memory. It buffers one returned instruction toward decode and discards wrong-path responses after a redirect. It sits between the PC register path, the instruction memory port and the decode stage.

---
 rtl/fetch_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: RV32 instruction-fetch controller.
// Owns the fetch PC and picks the next fetch address (trap > redirect > pc+4).
// Drives a single-outstanding valid/ready request to instruction memory.
// Holds one returned instruction for decode and drops wrong-path responses.
// Optional build macro FETCH_SEQ_PERF_EN adds perf_fetch_count and
// perf_squash_count output ports.
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// REQ   | request presented at pc_out, waiting for imem_req_ready
// WAIT  | request accepted, waiting for imem_rsp_valid
// HOLD  | instruction held for decode (inst_valid=1)
// FAULT | misaligned redirect seen; no requests until a trap arrives
module fetch_sequencer #(
    parameter int                   BIT_WIDTH    = 32,
    parameter logic [BIT_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [BIT_WIDTH-1:0] TRAP_VECTOR  = BIT_WIDTH'(32'h0000_0100)
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [BIT_WIDTH-1:0] imem_addr,
    input  logic                 imem_rsp_valid,
    input  logic [31:0]          imem_rsp_data,
    output logic                 inst_valid,
    output logic [31:0]          inst_data,
    output logic [BIT_WIDTH-1:0] inst_pc,
    input  logic                 inst_ready,
    input  logic                 redirect_valid,
    input  logic [BIT_WIDTH-1:0] redirect_target,
    input  logic                 trap_valid,
    output logic [BIT_WIDTH-1:0] pc_out,
`ifdef FETCH_SEQ_PERF_EN
    output logic [31:0]          perf_fetch_count,
    output logic [31:0]          perf_squash_count,
`endif
    output logic                 misaligned_fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t               state;
    logic [BIT_WIDTH-1:0] pc;
    logic [BIT_WIDTH-1:0] pending_pc;
    logic                 kill;

    logic                 evt;
    logic [BIT_WIDTH-1:0] evt_target;
    logic                 misaligned;

    // A trap overrides a redirect in the same cycle; a trap target is never
    // misaligned, so only an unmasked redirect can raise the fault.
    assign evt        = trap_valid | redirect_valid;
    assign evt_target = trap_valid ? TRAP_VECTOR : redirect_target;
    assign misaligned = redirect_valid && !trap_valid && (redirect_target[1:0] != 2'b00);

    assign pc_out    = pc;
    assign imem_addr = pc;

    // Fetch FSM with registered outputs; imem_req_valid is high exactly in REQ.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            pc               <= RESET_VECTOR;
            pending_pc       <= RESET_VECTOR;
            kill             <= 1'b0;
            imem_req_valid   <= 1'b0;
            inst_valid       <= 1'b0;
            inst_data        <= '0;
            inst_pc          <= '0;
            misaligned_fault <= 1'b0;
        end else begin
            misaligned_fault <= 1'b0;
            if (state != FAULT && misaligned) begin
                // Drop everything in flight or held; only a trap gets us out.
                state            <= FAULT;
                misaligned_fault <= 1'b1;
                kill             <= 1'b0;
                imem_req_valid   <= 1'b0;
                inst_valid       <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (evt) begin
                            pc <= evt_target;
                        end
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                    end
                    REQ: begin
                        // The address must stay stable, so a redirect is parked.
                        if (evt) begin
                            pending_pc <= evt_target;
                            kill       <= 1'b1;
                        end
                        if (imem_req_ready) begin
                            state          <= WAIT;
                            imem_req_valid <= 1'b0;
                        end
                    end
                    WAIT: begin
                        if (imem_rsp_valid) begin
                            if (kill || evt) begin
                                pc             <= evt ? evt_target : pending_pc;
                                kill           <= 1'b0;
                                state          <= REQ;
                                imem_req_valid <= 1'b1;
                            end else begin
                                inst_data  <= imem_rsp_data;
                                inst_pc    <= pc;
                                inst_valid <= 1'b1;
                                state      <= HOLD;
                            end
                        end else if (evt) begin
                            pending_pc <= evt_target;
                            kill       <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (evt) begin
                            pc             <= evt_target;
                            inst_valid     <= 1'b0;
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end else if (inst_ready) begin
                            pc             <= pc + BIT_WIDTH'(4);
                            inst_valid     <= 1'b0;
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end
                    end
                    FAULT: begin
                        if (trap_valid) begin
                            pc             <= TRAP_VECTOR;
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end
                    end
                    default: begin
                        state          <= IDLE;
                        imem_req_valid <= 1'b0;
                        inst_valid     <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef FETCH_SEQ_PERF_EN
    logic fetch_fire;
    logic squash_fire;

    // A transfer counts only if no redirect/trap squashes it in the same cycle.
    assign fetch_fire  = (state == HOLD) && inst_ready && !evt;
    assign squash_fire = ((state == HOLD) && evt) ||
                         ((state == WAIT) && imem_rsp_valid && (kill || evt));

    // Free-running, wrapping performance counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetch_count  <= '0;
            perf_squash_count <= '0;
        end else begin
            if (fetch_fire) begin
                perf_fetch_count <= perf_fetch_count + 32'd1;
            end
            if (squash_fire) begin
                perf_squash_count <= perf_squash_count + 32'd1;
            end
        end
    end
`endif

endmodule
